add_sequencer: RTL

Byte-serial multi-byte add engine that shares one 8-bit carry-chained adder slice between two requesters. Each requester submits a full-width add (A + B + carry-in). A round-robin arbiter grants the slice and an FSM walks it LSB-byte first, one byte per cycle. The result is returned on a single valid/ready result port tagged with the requester ID. It sits between the pin-level operand capture logic and the output mux of the top-level wrapper, replacing a direct full-width combinational add.

---
 rtl/add_seq_pkg.sv | 19 +
 rtl/add_sequencer_if.sv | 48 ++++
 rtl/adder_slice.sv | 22 ++
 rtl/add_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared types and defaults for the byte-serial add sequencer.
//   state_e   - sequencer FSM states
//   req_id_t  - requester identifier (0 or 1)
//   DefW      - default adder slice width
//   DefNbytes - default number of slices per operand
package add_seq_pkg;

   localparam int unsigned DefW      = 8;
   localparam int unsigned DefNbytes = 4;

   typedef logic req_id_t;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/add_sequencer_if.sv
// add_sequencer_if: request, result and status signals of the add sequencer.
//   req0_* / req1_* - valid/ready request channels with operands a, b and carry-in
//   res_*           - valid/ready result channel: sum, carry-out, owning requester id
//   busy            - engine not idle
// Modports: master = requesters plus result consumer, slave = the sequencer.
interface add_sequencer_if #(
   parameter int unsigned W      = 8,
   parameter int unsigned NBYTES = 4
);
   import add_seq_pkg::*;

   logic                  req0_valid;
   logic                  req0_ready;
   logic [W*NBYTES-1:0]   req0_a;
   logic [W*NBYTES-1:0]   req0_b;
   logic                  req0_cin;

   logic                  req1_valid;
   logic                  req1_ready;
   logic [W*NBYTES-1:0]   req1_a;
   logic [W*NBYTES-1:0]   req1_b;
   logic                  req1_cin;

   logic                  res_valid;
   logic                  res_ready;
   logic [W*NBYTES-1:0]   res_sum;
   logic                  res_cout;
   req_id_t               res_id;

   logic                  busy;

   modport master (
      output req0_valid, req0_a, req0_b, req0_cin,
      output req1_valid, req1_a, req1_b, req1_cin,
      output res_ready,
      input  req0_ready, req1_ready,
      input  res_valid, res_sum, res_cout, res_id, busy
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_cin,
      input  req1_valid, req1_a, req1_b, req1_cin,
      input  res_ready,
      output req0_ready, req1_ready,
      output res_valid, res_sum, res_cout, res_id, busy
   );

endinterface

// File: rtl/adder_slice.sv
// adder_slice: combinational W-bit adder, a + b + carry-in.
//   a_i, b_i  - operand slices
//   cin_i     - carry in
//   sum_o     - W-bit sum
//   cout_o    - carry out
module adder_slice #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o
);

   logic [W:0] full;

   assign full   = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
   assign sum_o  = full[W-1:0];
   assign cout_o = full[W];

endmodule

// File: rtl/add_sequencer.sv
// add_sequencer: shares one W-bit adder slice between two requesters and walks a
// W*NBYTES-bit add through it LSB byte first, one byte per cycle.
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset; discards any in-flight operation
//   bus  - add_sequencer_if slave: two request channels, one tagged result channel, busy
module add_sequencer
   import add_seq_pkg::*;
#(
   parameter int unsigned W      = DefW,
   parameter int unsigned NBYTES = DefNbytes
) (
   input  logic           clk,
   input  logic           rst,
   add_sequencer_if.slave bus
);

   localparam int unsigned OpW   = W * NBYTES;
   localparam int unsigned KW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [KW-1:0] KLast = KW'(NBYTES - 1);

   state_e          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   req_id_t         last_id_q, last_id_d;
   req_id_t         id_q, id_d;
   logic [OpW-1:0]  a_q, a_d;
   logic [OpW-1:0]  b_q, b_d;
   logic [OpW-1:0]  sum_q, sum_d;
   logic            carry_q, carry_d;

   // Arbiter: lone requester always wins, contention goes to the one not served last.
   logic    gnt_valid;
   req_id_t gnt_id;

   always_comb begin
      gnt_valid = bus.req0_valid | bus.req1_valid;
      gnt_id    = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         gnt_id = ~last_id_q;
      end else if (bus.req1_valid) begin
         gnt_id = 1'b1;
      end
   end

   // Reset gates the handshake so ready stays low while rst is held.
   logic hs;
   assign hs = (state_q == StIdle) && gnt_valid && !rst;

   logic [OpW-1:0] sel_a, sel_b;
   logic           sel_cin;

   assign sel_a   = gnt_id ? bus.req1_a   : bus.req0_a;
   assign sel_b   = gnt_id ? bus.req1_b   : bus.req0_b;
   assign sel_cin = gnt_id ? bus.req1_cin : bus.req0_cin;

   logic [W-1:0] slice_a, slice_b, slice_sum;
   logic         slice_cout;

   assign slice_a = a_q[k_q*W +: W];
   assign slice_b = b_q[k_q*W +: W];

   adder_slice #(
      .W (W)
   ) u_slice (
      .a_i    (slice_a),
      .b_i    (slice_b),
      .cin_i  (carry_q),
      .sum_o  (slice_sum),
      .cout_o (slice_cout)
   );

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      last_id_d = last_id_q;
      id_d      = id_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      carry_d   = carry_q;

      unique case (state_q)
         StIdle: begin
            if (hs) begin
               a_d       = sel_a;
               b_d       = sel_b;
               carry_d   = sel_cin;
               id_d      = gnt_id;
               last_id_d = gnt_id;
               k_d       = '0;
               sum_d     = '0;
               state_d   = StRun;
            end
         end
         StRun: begin
            sum_d[k_q*W +: W] = slice_sum;
            carry_d           = slice_cout;
            if (k_q == KLast) begin
               k_d     = '0;
               state_d = StDone;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         StDone: begin
            if (bus.res_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         k_q       <= '0;
         last_id_q <= 1'b1;
         id_q      <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         last_id_q <= last_id_d;
         id_q      <= id_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sum_q     <= sum_d;
         carry_q   <= carry_d;
      end
   end

   // Result fields read as zero outside DONE so partial sums never leak out.
   logic done;
   assign done = (state_q == StDone);

   assign bus.req0_ready = hs && (gnt_id == 1'b0);
   assign bus.req1_ready = hs && (gnt_id == 1'b1);
   assign bus.res_valid  = done;
   assign bus.res_sum    = done ? sum_q : '0;
   assign bus.res_cout   = done & carry_q;
   assign bus.res_id     = done & id_q;
   assign bus.busy       = (state_q != StIdle);

endmodule
